// File: rtl/rv32i_types.sv
// Shared widths and FSM state encodings for the data-memory line responder.
package rv32i_types;

    localparam int LINE_BYTES = 32;
    localparam int LINE_BITS  = LINE_BYTES * 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_FILL_REQ  = 3'd1;
    localparam state_t S_FILL_DATA = 3'd2;
    localparam state_t S_WB        = 3'd3;
    localparam state_t S_RESP      = 3'd4;

endpackage

// File: rtl/dmem_line_responder_line_merge.sv
// Byte-enable merge of one 32-bit word into a full line at a given word slot.
module line_merge
    import rv32i_types::*;
(
    input  logic [LINE_BITS-1:0] i_line,
    input  logic [2:0]           i_word_idx,
    input  logic [3:0]           i_wmask,
    input  logic [31:0]          i_wdata,
    output logic [LINE_BITS-1:0] o_line
);

    always_comb begin
        o_line = i_line;
        for (int b = 0; b < 4; b++) begin
            if (i_wmask[b]) begin
                o_line[{i_word_idx, 2'(b), 3'b000} +: 8] = i_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_line_responder.sv
// One-line write-through buffer between a 32-bit load/store port and a
// backing memory that moves 32-byte lines as four 64-bit beats.
module dmem_line_responder
    import rv32i_types::*;
#(
    parameter int LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    output logic        bmem_write,
    output logic [63:0] bmem_wdata,
    input  logic        bmem_ready,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid
);

    localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

    state_t               r_state;
    logic [1:0]           r_cnt;
    logic                 r_valid;
    logic [26:0]          r_tag;
    logic [LINE_BITS-1:0] r_line;
    logic [31:2]          r_addr;
    logic [3:0]           r_wmask;
    logic [31:0]          r_wdata;
    logic                 r_is_store;

    logic                 w_idle;
    logic                 w_req;
    logic                 w_store;
    logic                 w_hit;
    logic [LINE_BITS-1:0] w_fill_line;
    logic [LINE_BITS-1:0] w_merge_src;
    logic [LINE_BITS-1:0] w_merged;
    logic [2:0]           w_merge_idx;
    logic [3:0]           w_merge_mask;
    logic [31:0]          w_merge_data;
    logic                 w_unused;

    assign w_idle   = (r_state == S_IDLE);
    assign w_req    = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
    assign w_store  = (dmem_wmask != 4'h0);
    assign w_hit    = r_valid && (r_tag == dmem_addr[31:5]);
    assign w_unused = &{1'b0, dmem_addr[1:0]};

    // Line as it stands once the beat arriving this cycle is written into slot r_cnt.
    always_comb begin
        w_fill_line = r_line;
        w_fill_line[{r_cnt, 6'b0} +: 64] = bmem_rdata;
    end

    // The merger serves a store hit straight from the request port in IDLE,
    // and the captured store (mask 0 for a load) on the last fill beat.
    always_comb begin
        if (w_idle) begin
            w_merge_src  = r_line;
            w_merge_idx  = dmem_addr[4:2];
            w_merge_mask = dmem_wmask;
            w_merge_data = dmem_wdata;
        end else begin
            w_merge_src  = w_fill_line;
            w_merge_idx  = r_addr[4:2];
            w_merge_mask = r_wmask;
            w_merge_data = r_wdata;
        end
    end

    line_merge u_line_merge (
        .i_line     (w_merge_src),
        .i_word_idx (w_merge_idx),
        .i_wmask    (w_merge_mask),
        .i_wdata    (w_merge_data),
        .o_line     (w_merged)
    );

    // bmem handshake: a read command or a write beat transfers on the rising edge
    // where it is asserted together with bmem_ready; read beats transfer on
    // bmem_rvalid alone and have no back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_valid    <= 1'b0;
            r_tag      <= '0;
            r_line     <= '0;
            r_addr     <= '0;
            r_wmask    <= 4'h0;
            r_wdata    <= 32'h0;
            r_is_store <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= dmem_addr[31:2];
                        r_wmask    <= dmem_wmask;
                        r_wdata    <= dmem_wdata;
                        r_is_store <= w_store;
                        r_cnt      <= 2'd0;
                        if (w_hit) begin
                            if (w_store) begin
                                r_line  <= w_merged;
                                r_state <= S_WB;
                            end else begin
                                r_state <= S_RESP;
                            end
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= S_FILL_REQ;
                        end
                    end
                end
                S_FILL_REQ: begin
                    if (bmem_ready) begin
                        r_state <= S_FILL_DATA;
                    end
                end
                S_FILL_DATA: begin
                    if (bmem_rvalid) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == LAST_BEAT) begin
                            r_line  <= w_merged;
                            r_valid <= 1'b1;
                            r_tag   <= r_addr[31:5];
                            r_state <= r_is_store ? S_WB : S_RESP;
                        end else begin
                            r_line <= w_fill_line;
                        end
                    end
                end
                S_WB: begin
                    if (bmem_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == LAST_BEAT) begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem_resp  = (r_state == S_RESP);
    assign dmem_rdata = (dmem_resp && !r_is_store) ? r_line[{r_addr[4:2], 5'b0} +: 32] : 32'h0;
    assign bmem_read  = (r_state == S_FILL_REQ);
    assign bmem_write = (r_state == S_WB);
    assign bmem_addr  = (bmem_read || bmem_write) ? {r_addr[31:5], 5'b0} : 32'h0;
    assign bmem_wdata = bmem_write ? r_line[{r_cnt, 6'b0} +: 64] : 64'h0;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Bench for dmem_line_responder: byte-addressed memory model plus a single-line
// hit/miss model predict every response and every backing-memory write beat.
module tb_dmem_line_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    dmem_line_responder #(.LINE_BEATS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dmem_addr   (dmem_addr),
        .dmem_rmask  (dmem_rmask),
        .dmem_wmask  (dmem_wmask),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_resp   (dmem_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [7:0]  mem [logic [31:0]];
    logic        m_valid = 1'b0;
    logic [26:0] m_tag   = '0;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [31:0] h;
        if (mem.exists(a)) return mem[a];
        h = a * 32'h9E37_79B1;
        return h[31:24];
    endfunction

    function automatic logic [63:0] mbeat(input logic [31:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mbyte(a + 32'(i));
        return r;
    endfunction

    function automatic logic [63:0] line_beat(input logic [7:0] l[32], input int b);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = l[8*b + i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- backing-memory responder ----------------
    int          rd_cmds         = 0;
    int          fill_beats_sent = 0;
    int          both_seen       = 0;
    int          rdata_leak      = 0;
    logic        ready_force_low = 1'b0;
    logic        fill_active     = 1'b0;
    logic [31:0] fill_base       = '0;
    int          fill_idx        = 0;
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];

    // Drives at each falling edge for the next rising edge; a transfer is logged
    // when the DUT's current command meets the ready value just driven.
    initial begin : bmem_side
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bmem_read === 1'b1 && bmem_write === 1'b1) both_seen++;
            if (dmem_resp !== 1'b1 && dmem_rdata !== 32'h0) rdata_leak++;
            if (!rst_n) begin
                fill_active = 1'b0;
                fill_idx    = 0;
                bmem_ready  = 1'b0;
                bmem_rvalid = 1'b0;
            end else begin
                bmem_ready = ready_force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (fill_active && $urandom_range(0, 2) != 0) begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = mbeat(fill_base + 32'(8 * fill_idx));
                    fill_idx++;
                    fill_beats_sent++;
                    if (fill_idx == 4) fill_active = 1'b0;
                end else if (!fill_active && $urandom_range(0, 4) == 0) begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = {$urandom, $urandom};
                end else begin
                    bmem_rvalid = 1'b0;
                    bmem_rdata  = {$urandom, $urandom};
                end
                if (bmem_read === 1'b1 && bmem_ready) begin
                    rd_cmds++;
                    rd_addr_q.push_back(bmem_addr);
                    fill_active = 1'b1;
                    fill_base   = bmem_addr;
                    fill_idx    = 0;
                end
                if (bmem_write === 1'b1 && bmem_ready) begin
                    wr_addr_q.push_back(bmem_addr);
                    wr_data_q.push_back(bmem_wdata);
                end
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic clear_req();
        dmem_addr  = $urandom;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = $urandom;
    endtask

    task automatic drive_garbage();
        dmem_addr  = $urandom;
        dmem_rmask = 4'($urandom_range(1, 15));
        dmem_wmask = 4'($urandom_range(0, 15));
        dmem_wdata = $urandom;
    endtask

    // Entered and left at 1 time unit after a falling edge with the DUT idle.
    task automatic do_req(input logic [31:0] addr, input logic [3:0] rmask, input logic [3:0] wmask,
                          input logic [31:0] wdata, input int hold, output logic [31:0] rdata_o);
        logic [31:0] line_a;
        logic        store;
        logic        exp_hit;
        logic        got;
        logic        hold_done;
        logic [7:0]  nb[32];
        logic [31:0] exp_rdata;
        logic [63:0] w0;
        int          lat;
        int          rd0;
        int          fb0;
        int          fb_at_resp;
        int          wr_at_resp;
        int          widx;

        line_a  = {addr[31:5], 5'b0};
        store   = (wmask != 4'h0);
        exp_hit = m_valid && (m_tag == addr[31:5]);
        widx    = int'(addr[4:2]);
        for (int i = 0; i < 32; i++) nb[i] = mbyte(line_a + 32'(i));
        if (store) begin
            for (int b = 0; b < 4; b++) if (wmask[b]) nb[widx*4 + b] = wdata[8*b +: 8];
        end
        exp_rdata = 32'h0;
        if (!store) begin
            for (int b = 0; b < 4; b++) exp_rdata[8*b +: 8] = nb[widx*4 + b];
        end

        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd0             = rd_cmds;
        fb0             = fill_beats_sent;
        ready_force_low = (hold > 0);
        hold_done       = 1'b0;
        got             = 1'b0;
        lat             = 0;
        fb_at_resp      = 0;
        wr_at_resp      = 0;
        rdata_o         = 32'h0;

        dmem_addr  = addr;
        dmem_rmask = rmask;
        dmem_wmask = wmask;
        dmem_wdata = wdata;

        while (!got && lat < 400) begin
            @(negedge clk);
            #1;
            lat++;
            if (hold > 0 && !hold_done && bmem_write === 1'b1) begin
                w0 = bmem_wdata;
                check("wb_stall_beat0", w0, line_beat(nb, 0));
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    #1;
                    lat++;
                    check("wb_stall_wdata", bmem_wdata, w0);
                    check("wb_stall_write", 64'(bmem_write), 64'd1);
                end
                ready_force_low = 1'b0;
                hold_done       = 1'b1;
            end
            if (dmem_resp === 1'b1) begin
                got        = 1'b1;
                rdata_o    = dmem_rdata;
                fb_at_resp = fill_beats_sent - fb0;
                wr_at_resp = wr_data_q.size();
                clear_req();
            end else begin
                drive_garbage();
            end
        end
        ready_force_low = 1'b0;
        if (!got) clear_req();

        check("resp_seen", 64'(got), 64'd1);
        if (exp_hit && !store) check("hit_latency", 64'(lat), 64'd1);
        check("rdata", 64'(rdata_o), 64'(exp_rdata));
        check("rd_cmds", 64'(rd_cmds - rd0), exp_hit ? 64'd0 : 64'd1);
        check("fill_beats", 64'(fb_at_resp), exp_hit ? 64'd0 : 64'd4);
        if (!exp_hit) check("rd_addr", (rd_addr_q.size() > 0) ? 64'(rd_addr_q[0]) : 64'hx, 64'(line_a));
        check("wr_beats", 64'(wr_at_resp), store ? 64'd4 : 64'd0);
        for (int i = 0; i < wr_at_resp && i < 4; i++) begin
            check("wr_addr", 64'(wr_addr_q[i]), 64'(line_a));
            check("wr_data", wr_data_q[i], line_beat(nb, i));
        end

        @(negedge clk);
        #1;
        check("resp_one_cycle", 64'(dmem_resp), 64'd0);

        if (store) begin
            for (int i = 0; i < 32; i++) mem[line_a + 32'(i)] = nb[i];
        end
        m_valid = 1'b1;
        m_tag   = addr[31:5];
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        logic [31:0] rd;
        logic [31:0] a;
        logic [3:0]  rm;
        logic [3:0]  wm;
        int          kind;
        int          s0;
        int          waited;

        rst_n = 1'b0;
        clear_req();
        repeat (3) @(negedge clk);
        #1;
        check("rst_resp", 64'(dmem_resp), 64'd0);
        check("rst_rdata", 64'(dmem_rdata), 64'd0);
        check("rst_read", 64'(bmem_read), 64'd0);
        check("rst_write", 64'(bmem_write), 64'd0);
        check("rst_baddr", 64'(bmem_addr), 64'd0);
        check("rst_bwdata", bmem_wdata, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Cold load miss, then a same-line hit with one-cycle latency.
        do_req(32'h1000_0004, 4'hF, 4'h0, 32'h0, 0, rd);
        check("cold_word_is_beat0_hi", 64'(rd), 64'(mbeat(32'h1000_0000) >> 32));
        do_req(32'h1000_0008, 4'hF, 4'h0, 32'h0, 0, rd);

        // Store hit into byte lane 1 of word 1, then read it back.
        do_req(32'h1000_0004, 4'h0, 4'b0010, 32'h0000_AB00, 0, rd);
        check("st_hit_beat0_byte", (wr_data_q.size() > 0) ? 64'(wr_data_q[0][47:40]) : 64'hx, 64'hAB);
        do_req(32'h1000_0004, 4'hF, 4'h0, 32'h0, 0, rd);
        check("merged_lane1", 64'(rd[15:8]), 64'hAB);

        // Store miss: fill, merge on the last beat, write back.
        do_req(32'h2000_0010, 4'h0, 4'hF, 32'hDEAD_BEEF, 0, rd);
        check("st_miss_beat2_lo", (wr_data_q.size() > 2) ? 64'(wr_data_q[2][31:0]) : 64'hx, 64'hDEAD_BEEF);

        // Store hit with bmem_ready held low for 5 cycles in write-back.
        do_req(32'h2000_0000, 4'h0, 4'b1001, $urandom, 5, rd);

        // Reset while a fill is in flight.
        dmem_addr  = 32'h3000_0008;
        dmem_rmask = 4'hF;
        dmem_wmask = 4'h0;
        s0         = fill_beats_sent;
        waited     = 0;
        while (fill_beats_sent == s0 && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
            clear_req();
        end
        check("rst_fill_started", 64'(fill_beats_sent != s0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_resp", 64'(dmem_resp), 64'd0);
        check("midrst_read", 64'(bmem_read), 64'd0);
        check("midrst_write", 64'(bmem_write), 64'd0);
        check("midrst_baddr", 64'(bmem_addr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midrst_resp_held", 64'(dmem_resp), 64'd0);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_no_resp", 64'(dmem_resp), 64'd0);
        do_req(32'h3000_0008, 4'hF, 4'h0, 32'h0, 0, rd);

        // Random mix over a few lines that alias and evict each other.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h1000_0000;
                1:       a = 32'h1000_0020;
                2:       a = 32'h2000_0000;
                default: a = 32'h4000_0040;
            endcase
            a    = a + 32'($urandom_range(0, 31));
            kind = $urandom_range(0, 2);
            rm   = (kind == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            wm   = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_req(a, rm, wm, $urandom, 0, rd);
        end

        check("rw_overlap", 64'(both_seen), 64'd0);
        check("rdata_outside_resp", 64'(rdata_leak), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_line_responder.md
DMEM_LINE_RESPONDER -- requirements
Module: dmem_line_responder

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 4, meaning the number of 64-bit beats per 32-byte line (fixed; other values unsupported).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port dmem_addr, input, 32 bits: word-aligned request address; bits [1:0] ignored.
REQ-005 SHALL have port dmem_rmask, input, 4 bits: load request strobe; any nonzero value is a load.
REQ-006 SHALL have port dmem_wmask, input, 4 bits: store byte enables; any nonzero value is a store.
REQ-007 SHALL have port dmem_wdata, input, 32 bits: store data, byte lanes aligned to the word.
REQ-008 SHALL have port dmem_rdata, output, 32 bits: load data, valid only while dmem_resp is high.
REQ-009 SHALL have port dmem_resp, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port bmem_addr, output, 32 bits: line address, bits [4:0] = 0.
REQ-011 SHALL have ports bmem_read and bmem_write, output, 1 bit each: backing-memory commands.
REQ-012 SHALL have port bmem_wdata, output, 64 bits: current write beat.
REQ-013 SHALL have port bmem_ready, input, 1 bit: accepts a read command or a write beat.
REQ-014 SHALL have port bmem_rdata, input, 64 bits, plus port bmem_rvalid, input, 1 bit: read beats, in order from beat 0.

Function
REQ-015 SHALL sample a request only in IDLE; a request is a cycle in which rmask or wmask is nonzero; nonzero wmask wins over rmask.
REQ-016 SHALL capture addr, wmask and wdata at acceptance; the inputs are don't-care afterwards.
REQ-017 SHALL ignore requests outside IDLE; the initiator guarantees one outstanding request.
REQ-018 SHALL hold a one-line buffer: valid bit, tag = addr[31:5], 256-bit data.
REQ-019 SHALL define a hit as valid && tag == addr[31:5].
REQ-020 SHALL implement states IDLE, FILL_REQ, FILL_DATA, WB, RESP.
REQ-021 Load hit, request in cycle N: SHALL go IDLE->RESP; dmem_resp=1 in N+1 with word addr[4:2] of the buffer.
REQ-022 Load or store miss: SHALL go IDLE->FILL_REQ; bmem_read=1 with bmem_addr={addr[31:5],5'b0} until the cycle bmem_ready=1; then FILL_DATA.
REQ-023 FILL_DATA: SHALL store each beat on bmem_rvalid into beat slot cnt (2-bit counter, wraps 3->0).
REQ-024 FILL_DATA, on the 4th beat: SHALL set valid and tag, and on the same edge merge pending store bytes; next state is RESP for a load, WB for a store.
REQ-025 Store hit: SHALL merge the wmask bytes into the buffer at acceptance and go IDLE->WB.
REQ-026 WB: SHALL assert bmem_write with bmem_addr = the line address and bmem_wdata = beat cnt; cnt advances on bmem_ready; after beat 3 is accepted, next state is RESP (write-through).
REQ-027 RESP: SHALL pulse dmem_resp for exactly one cycle, then return to IDLE.
REQ-028 Store response: dmem_rdata SHALL be 0.
REQ-029 Outside RESP: dmem_resp=0 and dmem_rdata=0.
REQ-030 SHALL never assert bmem_read and bmem_write in the same cycle.
REQ-031 SHALL ignore bmem_rvalid outside FILL_DATA.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, cnt=0, buffer valid=0, all outputs 0.
REQ-033 Reset mid-FILL or mid-WB SHALL abort the transaction with no response; the buffer data is unspecified but invalid.

Structure
REQ-034 SHALL place the state enum and LINE_BYTES=32 in rv32i_types.
REQ-035 SHALL have one natural sub-module, line_merge: combinational byte-mask merge of 32-bit data into a 256-bit line at word index addr[4:2].

Verification
REQ-036 Cold load 0x1000_0004, bmem returns beats 0x...; dmem_resp once after beat 3, rdata = beat0[63:32]; bmem_read seen exactly once.
REQ-037 Back-to-back load 0x1000_0008 after REQ-036: dmem_resp in N+1, no bmem activity.
REQ-038 Store hit 0x1000_0004, wmask=4'b0010, wdata=0x0000_AB00: exactly 4 write beats, beat0[47:40]=0xAB; a following load returns the merged word.
REQ-039 Store miss 0x2000_0010, wmask=4'hF, wdata=0xDEAD_BEEF: fill, then write-back; beat2[31:0]=0xDEAD_BEEF; dmem_resp after beat 3.
REQ-040 bmem_ready held low 5 cycles in WB: bmem_wdata stable and cnt frozen; rst_n deasserted mid-FILL: returns to IDLE, dmem_resp=0, next same-line load misses.
